// File: rtl/wb_sram_slave.sv
// Wishbone B4 slave terminating an interconnect port with on-chip word-addressed SRAM.
// Define WB_SRAM_SLAVE_BURST_EN to compile in back-to-back incrementing/wrap bursts.
module wb_sram_slave #(
  parameter int unsigned              WB_ADDR_WIDTH = 32,
  parameter int unsigned              WB_DATA_WIDTH = 32,
  parameter int unsigned              MEM_DEPTH     = 1024,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = 'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WB_ADDR_WIDTH-1:0]     s_adr,
  input  logic [2:0]                   s_cti,
  input  logic [1:0]                   s_bte,
  input  logic [WB_DATA_WIDTH-1:0]     s_dat_w,
  input  logic [WB_DATA_WIDTH/8-1:0]   s_sel,
  input  logic                         s_cyc,
  input  logic                         s_stb,
  input  logic                         s_we,
  output logic [WB_DATA_WIDTH-1:0]     s_dat_r,
  output logic                         s_ack,
  output logic                         s_err
);

  localparam int unsigned BYTES = WB_DATA_WIDTH / 8;
  localparam int unsigned OFS_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int unsigned IW    = WB_ADDR_WIDTH - OFS_W;
  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

`ifdef WB_SRAM_SLAVE_BURST_EN
  localparam logic [2:0] CTI_INC = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    BURST = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1
  } state_t;
`endif

  logic [WB_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                   state_q;
  state_t                   state_d;
  logic                     ack_d;
  logic                     err_d;
  logic                     wr_en;
  logic                     req;
  logic                     below;
  logic                     in_range;
  logic [WB_ADDR_WIDTH-1:0] adr_off;
  logic [IW-1:0]            widx;
  logic [IDX_W-1:0]         mem_idx;

  // Address decode: byte offset bits are dropped, range checked against both ends.
  assign req      = s_cyc & s_stb;
  assign below    = s_adr < BASE_ADDR;
  assign adr_off  = s_adr - BASE_ADDR;
  assign widx     = IW'(adr_off >> OFS_W);
  assign in_range = !below && (widx < IW'(MEM_DEPTH));
  assign mem_idx  = IDX_W'(widx);

`ifdef WB_SRAM_SLAVE_BURST_EN
  logic [IW-1:0] cnt_q;
  logic [IW-1:0] cnt_d;

  // Next predicted index; wrap modes only advance the low bits of the index.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx, input logic [1:0] bte);
    logic [IW-1:0] inc;
    logic [IW-1:0] mask;
    inc = idx + IW'(1);
    case (bte)
      2'b01:   mask = IW'(3);
      2'b10:   mask = IW'(7);
      2'b11:   mask = IW'(15);
      default: mask = '1;
    endcase
    return (idx & ~mask) | (inc & mask);
  endfunction
`else
  logic unused_burst_sigs;
  assign unused_burst_sigs = ^{s_cti, s_bte};
`endif

  // Next-state and response decision for the request sampled at this edge.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
`ifdef WB_SRAM_SLAVE_BURST_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = RESP;
          if (!in_range) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            wr_en = s_we;
`ifdef WB_SRAM_SLAVE_BURST_EN
            if (s_cti == CTI_INC) begin
              state_d = BURST;
              cnt_d   = next_idx(widx, s_bte);
            end
`endif
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
`ifdef WB_SRAM_SLAVE_BURST_EN
      BURST: begin
        // A dropped strobe or an unpredicted address ends the burst without a response.
        if (!req || below || (widx != cnt_q)) begin
          state_d = IDLE;
        end else if (!in_range) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          ack_d = 1'b1;
          wr_en = s_we;
          cnt_d = next_idx(cnt_q, s_bte);
          if (s_cti != CTI_INC) begin
            state_d = IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_ack   <= 1'b0;
      s_err   <= 1'b0;
      s_dat_r <= '0;
`ifdef WB_SRAM_SLAVE_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_ack   <= ack_d;
      s_err   <= err_d;
`ifdef WB_SRAM_SLAVE_BURST_EN
      cnt_q   <= cnt_d;
`endif
      if (ack_d) begin
        s_dat_r <= mem[mem_idx];
      end else if (err_d) begin
        s_dat_r <= '0;
      end
    end
  end

  // Byte-lane write commit; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (s_sel[i]) begin
          mem[mem_idx][8*i +: 8] <= s_dat_w[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed self-checking bench for wb_sram_slave (32-bit bus, 1024 words, base 0).
`timescale 1ns/1ps
module tb_wb_sram_slave;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] s_adr;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;
  logic [DW-1:0] s_dat_w;
  logic [3:0]    s_sel;
  logic          s_cyc;
  logic          s_stb;
  logic          s_we;
  logic [DW-1:0] s_dat_r;
  logic          s_ack;
  logic          s_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] c_rd;
  logic        c_ack;
  logic        c_err;
  logic        c_after;
  int          c_lat;

  logic [31:0] b_adr [4];
  logic [31:0] b_dat [4];
  logic [2:0]  b_cti [4];
  logic        b_ack [4];
  logic        b_err [4];
  logic [31:0] b_rd  [4];
  logic        b_tail;

  always #5 clk = ~clk;

  wb_sram_slave #(
    .WB_ADDR_WIDTH(AW),
    .WB_DATA_WIDTH(DW),
    .MEM_DEPTH    (1024),
    .BASE_ADDR    (32'h0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_adr  (s_adr),
    .s_cti  (s_cti),
    .s_bte  (s_bte),
    .s_dat_w(s_dat_w),
    .s_sel  (s_sel),
    .s_cyc  (s_cyc),
    .s_stb  (s_stb),
    .s_we   (s_we),
    .s_dat_r(s_dat_r),
    .s_ack  (s_ack),
    .s_err  (s_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    s_adr = '0; s_dat_w = '0; s_sel = '0; s_cti = '0; s_bte = '0;
  endtask

  task automatic drive(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat, input logic [2:0] cti, input logic [1:0] bte);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = we;
    s_adr = adr; s_dat_w = dat; s_sel = sel; s_cti = cti; s_bte = bte;
  endtask

  // Single access holding the request until ACK/ERR, bounded to 8 cycles.
  task automatic classic(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat, input logic [2:0] cti);
    drive(adr, we, sel, dat, cti, 2'b00);
    c_lat = 0; c_ack = 1'b0; c_err = 1'b0;
    while (!c_ack && !c_err && c_lat < 8) begin
      tick();
      c_lat++;
      c_ack = s_ack;
      c_err = s_err;
    end
    c_rd = s_dat_r;
    tick();
    bus_idle();
    c_after = s_ack | s_err;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    classic(adr, 1'b1, 4'hF, dat, 3'b000);
  endtask

  task automatic rd(input logic [31:0] adr);
    classic(adr, 1'b0, 4'hF, 32'h0, 3'b000);
  endtask

  task automatic set_beat(input int k, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [2:0] cti);
    b_adr[k] = adr; b_dat[k] = dat; b_cti[k] = cti;
  endtask

  // Back-to-back burst master: a new beat every cycle, responses sampled one cycle later.
  task automatic burst(input int n, input logic we, input logic [1:0] bte);
    drive(b_adr[0], we, 4'hF, b_dat[0], b_cti[0], bte);
    for (int k = 0; k < n; k++) begin
      tick();
      b_ack[k] = s_ack;
      b_err[k] = s_err;
      b_rd[k]  = s_dat_r;
      if (k + 1 < n) drive(b_adr[k+1], we, 4'hF, b_dat[k+1], b_cti[k+1], bte);
      else bus_idle();
    end
    tick();
    b_tail = s_ack | s_err;
  endtask

  initial begin
    rst = 1'b1;
    bus_idle();
    repeat (3) tick();
    check("reset_ack",   32'(s_ack), 32'h0);
    check("reset_err",   32'(s_err), 32'h0);
    check("reset_dat_r", s_dat_r,    32'h0);
    rst = 1'b0;
    tick();

    classic(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 3'b000);
    check("wr_ack",       32'(c_ack),   32'h1);
    check("wr_latency",   32'(c_lat),   32'h1);
    check("wr_no_err",    32'(c_err),   32'h0);
    check("wr_ack_pulse", 32'(c_after), 32'h0);
    rd(32'h10);
    check("rd_data",    c_rd,        32'hDEADBEEF);
    check("rd_latency", 32'(c_lat),  32'h1);
    rd(32'h13);
    check("rd_offset_ignored", c_rd, 32'hDEADBEEF);

    wr(32'h20, 32'h11223344);
    classic(32'h20, 1'b1, 4'b0101, 32'hAABBCCDD, 3'b000);
    rd(32'h20);
    check("byte_lanes", c_rd, 32'h11BB33DD);

    wr(32'hFF8, 32'h0000_0FF8);
    wr(32'hFFC, 32'hCAFEF00D);
    rd(32'hFFC);
    check("last_word", c_rd, 32'hCAFEF00D);

    wr(32'h0, 32'h0BADF00D);
    rd(32'h1000);
    check("oor_err",     32'(c_err), 32'h1);
    check("oor_no_ack",  32'(c_ack), 32'h0);
    check("oor_dat_r",   c_rd,       32'h0);
    check("oor_latency", 32'(c_lat), 32'h1);
    classic(32'h1000, 1'b1, 4'hF, 32'h12345678, 3'b000);
    check("oor_wr_err", 32'(c_err), 32'h1);
    rd(32'h0);
    check("oor_no_alias", c_rd, 32'h0BADF00D);

`ifdef WB_SRAM_SLAVE_BURST_EN
    for (int k = 0; k < 4; k++)
      set_beat(k, 32'h40 + 32'(4 * k), 32'(k + 1), (k == 3) ? 3'b111 : 3'b010);
    burst(4, 1'b1, 2'b00);
    for (int k = 0; k < 4; k++) check($sformatf("lin_wr_ack%0d", k), 32'(b_ack[k]), 32'h1);
    check("lin_wr_tail", 32'(b_tail), 32'h0);
    burst(4, 1'b0, 2'b00);
    for (int k = 0; k < 4; k++) check($sformatf("lin_rd_data%0d", k), b_rd[k], 32'(k + 1));

    wr(32'h00, 32'hA0); wr(32'h04, 32'hA1); wr(32'h08, 32'hA2); wr(32'h0C, 32'hA3);
    set_beat(0, 32'h0C, 0, 3'b010);
    set_beat(1, 32'h00, 0, 3'b010);
    set_beat(2, 32'h04, 0, 3'b010);
    set_beat(3, 32'h08, 0, 3'b111);
    burst(4, 1'b0, 2'b01);
    check("wrap_ack0", 32'(b_ack[0]), 32'h1);
    check("wrap_ack3", 32'(b_ack[3]), 32'h1);
    check("wrap_d0", b_rd[0], 32'hA3);
    check("wrap_d1", b_rd[1], 32'hA0);
    check("wrap_d2", b_rd[2], 32'hA1);
    check("wrap_d3", b_rd[3], 32'hA2);

    drive(32'h0C, 1'b0, 4'hF, 32'h0, 3'b010, 2'b01);
    tick();
    check("mm_beat0_ack", 32'(s_ack), 32'h1);
    drive(32'h10, 1'b0, 4'hF, 32'h0, 3'b000, 2'b01);
    tick();
    check("mm_ack_dropped", 32'(s_ack), 32'h0);
    check("mm_no_err",      32'(s_err), 32'h0);
    tick();
    check("mm_reserved_ack",  32'(s_ack), 32'h1);
    check("mm_reserved_data", s_dat_r,    32'hDEADBEEF);
    tick();
    bus_idle();
    check("mm_reserved_pulse", 32'(s_ack), 32'h0);
    tick();

    set_beat(0, 32'hFF8,  0, 3'b010);
    set_beat(1, 32'hFFC,  0, 3'b010);
    set_beat(2, 32'h1000, 0, 3'b111);
    burst(3, 1'b0, 2'b00);
    check("cross_ack0",   32'(b_ack[0]), 32'h1);
    check("cross_ack1",   32'(b_ack[1]), 32'h1);
    check("cross_d1",     b_rd[1],       32'hCAFEF00D);
    check("cross_err2",   32'(b_err[2]), 32'h1);
    check("cross_noack2", 32'(b_ack[2]), 32'h0);
    check("cross_dat_r2", b_rd[2],       32'h0);
`else
    for (int k = 0; k < 4; k++) begin
      classic(32'h40 + 32'(4 * k), 1'b1, 4'hF, 32'(k + 1), (k == 3) ? 3'b111 : 3'b010);
      check($sformatf("nb_wr_ack%0d", k),   32'(c_ack),   32'h1);
      check($sformatf("nb_wr_pulse%0d", k), 32'(c_after), 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      classic(32'h40 + 32'(4 * k), 1'b0, 4'hF, 32'h0, (k == 3) ? 3'b111 : 3'b010);
      check($sformatf("nb_rd_data%0d", k), c_rd, 32'(k + 1));
    end
`endif

    wr(32'h80, 32'h55000000); wr(32'h84, 32'h55000001);
    wr(32'h88, 32'h55000002); wr(32'h8C, 32'h55000003);
    drive(32'h80, 1'b1, 4'hF, 32'h1111, 3'b010, 2'b00);
    tick();
    check("rstb_beat0_ack", 32'(s_ack), 32'h1);
    drive(32'h84, 1'b1, 4'hF, 32'h2222, 3'b010, 2'b00);
    rst = 1'b1;
    tick();
    check("rstb_ack_low", 32'(s_ack), 32'h0);
    check("rstb_err_low", 32'(s_err), 32'h0);
    drive(32'h88, 1'b1, 4'hF, 32'h3333, 3'b010, 2'b00);
    tick();
    drive(32'h8C, 1'b1, 4'hF, 32'h4444, 3'b111, 2'b00);
    tick();
    bus_idle();
    rst = 1'b0;
    tick();
    rd(32'h80);
    check("rstb_beat0_kept", c_rd, 32'h1111);
    rd(32'h84);
    check("rstb_beat1_unwritten", c_rd, 32'h55000001);
    rd(32'h88);
    check("rstb_beat2_unwritten", c_rd, 32'h55000002);
    rd(32'h8C);
    check("rstb_beat3_unwritten", c_rd, 32'h55000003);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
